// File: rtl/ttt_pkg.sv
// ttt_pkg: cell encodings, arbiter states and the one-hot to cell index helper
package ttt_pkg;
    localparam int NUM_CELLS = 9;
    localparam logic [3:0] CELL_A = 4'd0;
    localparam logic [3:0] CELL_B = 4'd1;
    localparam logic [3:0] CELL_C = 4'd2;
    localparam logic [3:0] CELL_D = 4'd3;
    localparam logic [3:0] CELL_E = 4'd4;
    localparam logic [3:0] CELL_F = 4'd5;
    localparam logic [3:0] CELL_G = 4'd6;
    localparam logic [3:0] CELL_H = 4'd7;
    localparam logic [3:0] CELL_I = 4'd8;
    localparam logic [3:0] CELL_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HELD    = 2'd1,
        LOCKOUT = 2'd2
    } arb_state_t;

    function automatic logic [3:0] cell_of(input logic [NUM_CELLS-1:0] v);
        cell_of = CELL_NONE;
        for (int k = NUM_CELLS - 1; k >= 0; k--)
            if (v[k]) cell_of = 4'(k);
    endfunction
endpackage

// File: rtl/ttt_debounce_bit.sv
// ttt_debounce_bit: synchronizer chain plus saturating debounce counter for one button
module ttt_debounce_bit
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
            if (sync[SYNC_STAGES-1] == stable)
                cnt <= '0;
            else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync[SYNC_STAGES-1];
                cnt    <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/ttt_button_conditioner.sv
// ttt_button_conditioner: debounces nine board buttons and emits one locked-out press pulse per physical press
module ttt_button_conditioner
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a_button,
    input  logic       b_button,
    input  logic       c_button,
    input  logic       d_button,
    input  logic       e_button,
    input  logic       f_button,
    input  logic       g_button,
    input  logic       h_button,
    input  logic       i_button,
    output logic       a_pulse,
    output logic       b_pulse,
    output logic       c_pulse,
    output logic       d_pulse,
    output logic       e_pulse,
    output logic       f_pulse,
    output logic       g_pulse,
    output logic       h_pulse,
    output logic       i_pulse,
    output logic       press_valid,
    output logic [3:0] cell_idx,
    output logic       locked
);
    logic [NUM_CELLS-1:0] raw, stable, stable_q, rise, pulse;
    arb_state_t state;

    assign raw = {i_button, h_button, g_button, f_button, e_button,
                  d_button, c_button, b_button, a_button};
    assign {i_pulse, h_pulse, g_pulse, f_pulse, e_pulse,
            d_pulse, c_pulse, b_pulse, a_pulse} = pulse;

    for (genvar k = 0; k < NUM_CELLS; k++) begin : g_db
        ttt_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_db (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[k]),
            .stable(stable[k])
        );
    end

    always_comb rise = stable & ~stable_q;

    // A press is accepted only when it is the sole button down; anything else locks out until all release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            stable_q    <= '0;
            pulse       <= '0;
            press_valid <= 1'b0;
            cell_idx    <= CELL_NONE;
            locked      <= 1'b0;
        end else begin
            stable_q    <= stable;
            pulse       <= '0;
            press_valid <= 1'b0;
            cell_idx    <= CELL_NONE;
            case (state)
                IDLE:
                    if (rise != '0) begin
                        locked <= 1'b1;
                        if ($onehot(rise) && (stable & ~rise) == '0) begin
                            pulse       <= rise;
                            press_valid <= 1'b1;
                            cell_idx    <= cell_of(rise);
                            state       <= HELD;
                        end else
                            state <= LOCKOUT;
                    end
                HELD:
                    if (rise != '0)
                        state <= LOCKOUT;
                    else if (stable == '0) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                LOCKOUT:
                    if (stable == '0) begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                default: begin
                    state  <= IDLE;
                    locked <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ttt_button_conditioner.sv
// tb_ttt_button_conditioner: directed scenario tasks with hand-computed latencies (19 cycles at defaults)
module tb_ttt_button_conditioner;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [8:0] btn = '0;
    logic [8:0] pul;
    logic       press_valid, locked;
    logic [3:0] cell_idx;

    int errors = 0;
    int checks = 0;
    int npulse, first_cyc, pv_bad;
    int pcnt[9];
    logic [3:0] first_idx;
    logic [3:0] seq[$];

    always #5 clk = ~clk;

    ttt_button_conditioner dut (
        .clk(clk), .reset(reset),
        .a_button(btn[0]), .b_button(btn[1]), .c_button(btn[2]),
        .d_button(btn[3]), .e_button(btn[4]), .f_button(btn[5]),
        .g_button(btn[6]), .h_button(btn[7]), .i_button(btn[8]),
        .a_pulse(pul[0]), .b_pulse(pul[1]), .c_pulse(pul[2]),
        .d_pulse(pul[3]), .e_pulse(pul[4]), .f_pulse(pul[5]),
        .g_pulse(pul[6]), .h_pulse(pul[7]), .i_pulse(pul[8]),
        .press_valid(press_valid), .cell_idx(cell_idx), .locked(locked)
    );

    // Steps n cycles, sampling 1 time unit after each rising edge and recording pulse activity
    task automatic run_count(input int n);
        npulse = 0; first_cyc = 0; pv_bad = 0; first_idx = 4'hE;
        foreach (pcnt[k]) pcnt[k] = 0;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            if (press_valid !== (|pul)) pv_bad++;
            if (|pul) begin
                npulse++;
                for (int k = 0; k < 9; k++) if (pul[k]) pcnt[k]++;
                if (first_cyc == 0) begin first_cyc = c; first_idx = cell_idx; end
                seq.push_back(cell_idx);
            end
        end
    endtask

    task automatic test_reset_held_button;
        btn = 9'b000000001;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({pul, press_valid, cell_idx, locked} !== {9'b0, 1'b0, 4'hF, 1'b0}) begin errors++;
            $display("FAIL reset_outputs got pul=%b pv=%b idx=%h lk=%b want 0/0/f/0", pul, press_valid, cell_idx, locked); end
        reset = 1'b1;
        run_count(25);
        checks++; if (npulse !== 1 || pcnt[0] !== 1) begin errors++;
            $display("FAIL a_single_pulse got npulse=%0d a=%0d want 1/1", npulse, pcnt[0]); end
        checks++; if (first_cyc !== 19) begin errors++;
            $display("FAIL a_latency got %0d want 19", first_cyc); end
        checks++; if (first_idx !== 4'd0 || pv_bad !== 0) begin errors++;
            $display("FAIL a_idx got idx=%h pv_bad=%0d want 0/0", first_idx, pv_bad); end
        checks++; if (locked !== 1'b1 || cell_idx !== 4'hF) begin errors++;
            $display("FAIL a_held got lk=%b idx=%h want 1/f", locked, cell_idx); end
        btn = '0;
        run_count(25);
        checks++; if (npulse !== 0 || locked !== 1'b0) begin errors++;
            $display("FAIL a_release got npulse=%0d lk=%b want 0/0", npulse, locked); end
    endtask

    task automatic test_bounce;
        npulse = 0;
        for (int c = 0; c < 40; c++) begin
            btn[4] = ((c / 3) % 2) == 0;
            run_count(1);
            checks++; if (npulse !== 0 || locked !== 1'b0) begin errors++;
                $display("FAIL e_bounce cycle %0d got npulse=%0d lk=%b want 0/0", c, npulse, locked); end
        end
        btn[4] = 1'b1;
        run_count(40);
        checks++; if (npulse !== 1 || pcnt[4] !== 1 || first_idx !== 4'd4) begin errors++;
            $display("FAIL e_pulse got npulse=%0d e=%0d idx=%h want 1/1/4", npulse, pcnt[4], first_idx); end
        checks++; if (first_cyc !== 19) begin errors++;
            $display("FAIL e_latency got %0d want 19", first_cyc); end
        btn = '0;
        run_count(25);
    endtask

    task automatic test_simultaneous;
        btn[1] = 1'b1; btn[7] = 1'b1;
        run_count(25);
        checks++; if (npulse !== 0 || locked !== 1'b1) begin errors++;
            $display("FAIL bh_lockout got npulse=%0d lk=%b want 0/1", npulse, locked); end
        btn = '0;
        run_count(25);
        checks++; if (npulse !== 0 || locked !== 1'b0) begin errors++;
            $display("FAIL bh_release got npulse=%0d lk=%b want 0/0", npulse, locked); end
    endtask

    task automatic test_overlap;
        btn[2] = 1'b1;
        run_count(25);
        checks++; if (pcnt[2] !== 1 || first_idx !== 4'd2) begin errors++;
            $display("FAIL c_press got c=%0d idx=%h want 1/2", pcnt[2], first_idx); end
        btn[6] = 1'b1;
        run_count(25);
        checks++; if (npulse !== 0 || locked !== 1'b1) begin errors++;
            $display("FAIL g_while_c got npulse=%0d lk=%b want 0/1", npulse, locked); end
        btn = '0;
        run_count(25);
        checks++; if (locked !== 1'b0) begin errors++;
            $display("FAIL cg_release got lk=%b want 0", locked); end
        btn[6] = 1'b1;
        run_count(25);
        checks++; if (npulse !== 1 || pcnt[6] !== 1 || first_idx !== 4'd6 || pv_bad !== 0) begin errors++;
            $display("FAIL g_press got npulse=%0d g=%0d idx=%h pv_bad=%0d want 1/1/6/0", npulse, pcnt[6], first_idx, pv_bad); end
        btn = '0;
        run_count(25);
    endtask

    task automatic test_long_hold;
        btn[3] = 1'b1;
        run_count(200);
        checks++; if (npulse !== 1 || pcnt[3] !== 1 || first_cyc !== 19) begin errors++;
            $display("FAIL d_hold got npulse=%0d d=%0d cyc=%0d want 1/1/19", npulse, pcnt[3], first_cyc); end
        btn = '0;
        run_count(25);
        checks++; if (npulse !== 0) begin errors++;
            $display("FAIL d_release got npulse=%0d want 0", npulse); end
        btn[3] = 1'b1;
        run_count(25);
        checks++; if (npulse !== 1 || pcnt[3] !== 1 || first_cyc !== 19 || first_idx !== 4'd3) begin errors++;
            $display("FAIL d_repress got npulse=%0d cyc=%0d idx=%h want 1/19/3", npulse, first_cyc, first_idx); end
        btn = '0;
        run_count(25);
    endtask

    task automatic test_reset_mid;
        btn[0] = 1'b1;
        run_count(25);
        reset = 1'b0;
        #1;
        checks++; if (locked !== 1'b0 || cell_idx !== 4'hF || pul !== 9'b0) begin errors++;
            $display("FAIL async_reset got lk=%b idx=%h pul=%b want 0/f/0", locked, cell_idx, pul); end
        btn = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        btn[8] = 1'b1;
        run_count(5);
        reset = 1'b0;
        #1;
        checks++; if ({pul, press_valid, cell_idx, locked} !== {9'b0, 1'b0, 4'hF, 1'b0}) begin errors++;
            $display("FAIL i_reset got pul=%b pv=%b idx=%h lk=%b want 0/0/f/0", pul, press_valid, cell_idx, locked); end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        run_count(25);
        checks++; if (npulse !== 1 || pcnt[8] !== 1 || first_cyc !== 19 || first_idx !== 4'd8) begin errors++;
            $display("FAIL i_after_reset got npulse=%0d cyc=%0d idx=%h want 1/19/8", npulse, first_cyc, first_idx); end
        btn = '0;
        run_count(25);
    endtask

    task automatic test_game;
        int order[9] = '{0, 3, 1, 5, 2, 4, 6, 7, 8};
        int total = 0;
        seq.delete();
        foreach (order[k]) begin
            btn[order[k]] = 1'b1;
            run_count(60);
            total += npulse;
            btn = '0;
            run_count(60);
            total += npulse;
        end
        checks++; if (total !== 9 || seq.size() !== 9) begin errors++;
            $display("FAIL game_count got %0d/%0d want 9", total, seq.size()); end
        for (int k = 0; k < 9 && k < seq.size(); k++) begin
            checks++; if (seq[k] !== 4'(order[k])) begin errors++;
                $display("FAIL game_idx[%0d] got %h want %h", k, seq[k], 4'(order[k])); end
        end
    endtask

    initial begin
        test_reset_held_button();
        test_bounce();
        test_simultaneous();
        test_overlap();
        test_long_hold();
        test_reset_mid();
        test_game();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
